// File: rtl/axi_status_poller.sv
// Periodically reads a remote status word over AXI4-Lite and publishes the two link-up bits.
// Define POLL_CHANGE_COUNT_EN to add 16-bit counters of 0->1 transitions on each link-up bit.
module axi_status_poller #(
  parameter int unsigned POLL_CYCLES    = 1000,
  parameter logic [31:0] STATUS_ADDR    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic        M_AXI_AWVALID,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_WVALID,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_BREADY,
  output logic        ss0_channel_up,
  output logic        ss1_channel_up,
  output logic        status_valid,
  output logic        status_change,
  output logic        read_error
`ifdef POLL_CHANGE_COUNT_EN
  ,
  output logic [15:0] ss0_up_count,
  output logic [15:0] ss1_up_count
`endif
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, ADDR, DATA} state_t;

  state_t        state, state_d;
  logic [PW-1:0] poll_cnt, poll_d;
  logic [TW-1:0] tout_cnt, tout_d;
  logic          accept, expired, good, change_d, err_d;

  // The write channels are never used; this block only ever reads.
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_AWADDR  = 32'h0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_WDATA   = 32'h0;
  assign M_AXI_WSTRB   = 4'h0;
  assign M_AXI_BREADY  = 1'b0;

  logic unused_rdata;
  assign unused_rdata = ^{M_AXI_RDATA[31:17], M_AXI_RDATA[15:1]};

  always_comb begin
    state_d = state;
    poll_d  = poll_cnt;
    tout_d  = tout_cnt;
    accept  = 1'b0;
    expired = 1'b0;
    unique case (state)
      WAIT: begin
        if (poll_cnt == '0) begin
          state_d = ADDR;
          tout_d  = '0;
        end else begin
          poll_d = poll_cnt - PW'(1);
        end
      end
      ADDR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          state_d = DATA;
          tout_d  = '0;
        end else if (tout_cnt == TOUT_LAST) begin
          expired = 1'b1;
        end else begin
          tout_d = tout_cnt + TW'(1);
        end
      end
      DATA: begin
        if (M_AXI_RREADY && M_AXI_RVALID) begin
          accept = 1'b1;
        end else if (tout_cnt == TOUT_LAST) begin
          expired = 1'b1;
        end else begin
          tout_d = tout_cnt + TW'(1);
        end
      end
      default: state_d = WAIT;
    endcase
    // Completion or abort both restart the poll interval from a full count.
    if (accept || expired) begin
      state_d = WAIT;
      poll_d  = POLL_LOAD;
    end
    good     = accept && (M_AXI_RRESP == 2'b00);
    change_d = good && ({M_AXI_RDATA[16], M_AXI_RDATA[0]} != {ss1_channel_up, ss0_channel_up});
    err_d    = (accept && (M_AXI_RRESP != 2'b00)) || expired;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= WAIT;
      poll_cnt       <= POLL_LOAD;
      tout_cnt       <= '0;
      M_AXI_ARVALID  <= 1'b0;
      M_AXI_ARADDR   <= 32'h0;
      M_AXI_RREADY   <= 1'b0;
      ss0_channel_up <= 1'b0;
      ss1_channel_up <= 1'b0;
      status_valid   <= 1'b0;
      status_change  <= 1'b0;
      read_error     <= 1'b0;
    end else begin
      state          <= state_d;
      poll_cnt       <= poll_d;
      tout_cnt       <= tout_d;
      M_AXI_ARVALID  <= (state_d == ADDR);
      M_AXI_ARADDR   <= (state_d == ADDR) ? STATUS_ADDR : 32'h0;
      M_AXI_RREADY   <= (state_d == DATA);
      status_change  <= change_d;
      read_error     <= err_d;
      if (good) begin
        ss0_channel_up <= M_AXI_RDATA[0];
        ss1_channel_up <= M_AXI_RDATA[16];
        status_valid   <= 1'b1;
      end
    end
  end

`ifdef POLL_CHANGE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ss0_up_count <= 16'h0;
      ss1_up_count <= 16'h0;
    end else if (good) begin
      if (M_AXI_RDATA[0] && !ss0_channel_up)  ss0_up_count <= ss0_up_count + 16'h1;
      if (M_AXI_RDATA[16] && !ss1_channel_up) ss1_up_count <= ss1_up_count + 16'h1;
    end
  end
`endif

endmodule

// File: doc/axi_status_poller.md
AXI_STATUS_POLLER -- requirements
Module: axi_status_poller

Interface
REQ-001 Parameter POLL_CYCLES, default 1000: idle cycles between the end of one read transaction and the next AR issue (minimum 1).
REQ-002 Parameter STATUS_ADDR, default 32'h0000_0000: AXI read address of the remote status word.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: maximum cycles spent in AR or R phase before abort.
REQ-004 clk  input  1  clock; every output is registered on its rising edge.
REQ-005 resetn  input  1  reset: synchronous, active-low.
REQ-006 M_AXI_ARADDR output 32, M_AXI_ARVALID output 1, M_AXI_ARPROT output 3, M_AXI_ARREADY input 1: AXI4-Lite read-address channel.
REQ-007 M_AXI_RDATA input 32, M_AXI_RRESP input 2, M_AXI_RVALID input 1, M_AXI_RREADY output 1: AXI4-Lite read-data channel.
REQ-008 M_AXI_AWVALID output 1, M_AXI_WVALID output 1, M_AXI_BREADY output 1, constant 0; AWADDR, WDATA, WSTRB, AWPROT outputs constant 0.
REQ-009 ss0_channel_up output 1: last good RDATA[0]; ss1_channel_up output 1: last good RDATA[16].
REQ-010 status_valid output 1: high once any read has completed with RRESP OKAY since reset.
REQ-011 status_change output 1: one-cycle pulse when either channel_up bit changes value on a good read.
REQ-012 read_error output 1: one-cycle pulse on a non-OKAY RRESP or a timeout.

Function
REQ-013 The block SHALL implement states WAIT, ADDR and DATA.
REQ-014 WAIT SHALL load a down-counter with POLL_CYCLES on entry and move to ADDR in the cycle after it reaches 0.
REQ-015 ADDR SHALL drive ARVALID=1, ARADDR=STATUS_ADDR and ARPROT=0, and SHALL hold them stable until the cycle ARVALID and ARREADY are both 1.
REQ-016 The ADDR-to-DATA transition SHALL occur in the cycle after that handshake, and ARVALID SHALL be 0 in DATA.
REQ-017 DATA SHALL drive RREADY=1 and SHALL accept RDATA/RRESP in the cycle RVALID and RREADY are both 1, then return to WAIT.
REQ-018 A same-cycle RVALID during ADDR SHALL be ignored, because RREADY is 0 in ADDR.
REQ-019 On accept with RRESP=0 (OKAY), ss0/ss1_channel_up and status_valid=1 SHALL update on the next cycle.
REQ-020 On a good read, status_change SHALL pulse on the same next cycle when the new bit values differ from the previous ones.
REQ-021 The first good read after reset SHALL compare against the reset values (0).
REQ-022 On accept with RRESP!=0, read_error SHALL pulse and the status outputs SHALL hold their previous values.
REQ-023 A timeout counter SHALL clear on entry to ADDR and to DATA and increment each cycle in those states.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1 without the handshake, the block SHALL pulse read_error, drop ARVALID/RREADY and return to WAIT; status outputs hold.
REQ-025 ARVALID SHALL never be deasserted before ARREADY except on timeout or reset.
REQ-026 Only one outstanding read SHALL exist at any time.
REQ-027 Counter widths SHALL be $clog2(param+1) bits, with no wrap before terminal count.

Reset
REQ-028 While resetn=0, the state SHALL be WAIT with the poll counter loaded.
REQ-029 While resetn=0, ARVALID, RREADY, ss0/ss1_channel_up, status_valid, status_change and read_error SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abort it, and no status update SHALL result.
REQ-031 The first AR after reset release SHALL be issued POLL_CYCLES+1 cycles later.

Configuration
REQ-032 Macro POLL_CHANGE_COUNT_EN, when defined, SHALL add outputs ss0_up_count and ss1_up_count, each output 16 bits.
REQ-033 Each up_count SHALL increment on every good read where its channel_up goes 0->1, and SHALL wrap from 16'hFFFF to 0.
REQ-034 Both up_count outputs SHALL reset to 0.
REQ-035 When POLL_CHANGE_COUNT_EN is undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 POLL_CYCLES=4, ARREADY held 1 -> ARVALID first rises 5 cycles after reset release; ARADDR=STATUS_ADDR.
REQ-037 Slave returns RDATA=32'h0001_0001 with RRESP=0 -> ss0=1, ss1=1, status_valid=1, one status_change pulse.
REQ-038 Next read returns 32'h0001_0000 -> ss0=0, ss1=1, status_change pulse; with POLL_CHANGE_COUNT_EN, ss0_up_count=1 and ss1_up_count=1.
REQ-039 RRESP=2 with RDATA=0 -> read_error pulse; ss0/ss1 unchanged; no status_change.
REQ-040 ARREADY held 0, TIMEOUT_CYCLES=8 -> ARVALID stable for 8 cycles, then read_error pulse and ARVALID=0; next poll retries.
REQ-041 resetn pulsed low during DATA -> RREADY=0 and all outputs 0 on the next cycle; a late RVALID is ignored.
